// File: rtl/rc_receiver_decoder.sv
// Four-channel RC receiver PWM decoder: measures pulse widths in microseconds,
// converts them to offset words and drives a failsafe when channels go silent.
module rc_receiver_decoder #(
  parameter int TICKS_PER_US = 50,
  parameter int MIN_US       = 1000,
  parameter int MID_US       = 1500,
  parameter int MAX_US       = 2000,
  parameter int GUARD_US     = 150,
  parameter int TIMEOUT_US   = 100000,
  parameter int OUT_W        = 12
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             rc_throttle,
  input  logic             rc_pitch,
  input  logic             rc_roll,
  input  logic             rc_yaw,
  output logic [OUT_W-1:0] throttle_offset,
  output logic [OUT_W-1:0] pitch_offset,
  output logic [OUT_W-1:0] roll_offset,
  output logic [OUT_W-1:0] yaw_offset,
  output logic [3:0]       offset_update,
  output logic [3:0]       pulse_error,
  output logic             failsafe
);

  localparam int PW = (TICKS_PER_US > 1) ? $clog2(TICKS_PER_US) : 1;
  localparam int SW = $clog2(TIMEOUT_US + 1);
  localparam int WW = 12;

  localparam logic [WW-1:0] W_SAT     = '1;
  localparam logic [WW-1:0] W_MIN     = WW'(MIN_US);
  localparam logic [WW-1:0] W_MID     = WW'(MID_US);
  localparam logic [WW-1:0] W_MAX     = WW'(MAX_US);
  localparam logic [WW-1:0] LONG_LIM  = WW'(MAX_US + GUARD_US);
  localparam logic [WW-1:0] SHORT_LIM = WW'(MIN_US - GUARD_US);
  localparam logic [SW-1:0] S_MAX     = SW'(TIMEOUT_US);

  typedef enum logic [1:0] {WAIT_LOW, IDLE, MEASURE} state_t;

  function automatic logic [WW-1:0] clamp_width(input logic [WW-1:0] w);
    if (w < W_MIN)      return W_MIN;
    else if (w > W_MAX) return W_MAX;
    else                return w;
  endfunction

  function automatic logic signed [OUT_W-1:0] to_offset(input logic [WW-1:0] w,
                                                        input logic [WW-1:0] base);
    logic signed [WW:0] d;
    d = $signed({1'b0, clamp_width(w)}) - $signed({1'b0, base});
    return d[OUT_W-1:0];
  endfunction

  logic [3:0] rc_raw;
  logic [3:0] sync_p0, sync_p1, sync_p2;
  logic [3:0] rise_p2, fall_p2;
  logic [PW-1:0] presc;
  logic us_tick;

  state_t state [4];
  state_t state_nxt [4];
  logic [WW-1:0] width [4];
  logic [WW-1:0] width_nxt [4];
  logic [WW-1:0] width_inc [4];
  logic [SW-1:0] silence [4];
  logic signed [OUT_W-1:0] off [4];
  logic [3:0] acc, rej, to_vec, seen, seen_nxt;
  logic fs_nxt;

  assign rc_raw = {rc_yaw, rc_roll, rc_pitch, rc_throttle};

  // stage p0/p1: two-flop synchronizer; stage p2: registered edge detect
  always_ff @(posedge clk) begin
    sync_p0 <= rc_raw;
    sync_p1 <= sync_p0;
    sync_p2 <= sync_p1;
    rise_p2 <= sync_p1 & ~sync_p2;
    fall_p2 <= ~sync_p1 & sync_p2;
  end

  assign us_tick = (presc == PW'(TICKS_PER_US - 1));

  always_ff @(posedge clk) begin
    if (!rst_n)       presc <= '0;
    else if (us_tick) presc <= '0;
    else              presc <= presc + 1'b1;
  end

  // The falling-edge cycle's tick is counted so a pulse of N us reads exactly N.
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      width_inc[i] = (us_tick && width[i] != W_SAT) ? width[i] + WW'(1) : width[i];
      state_nxt[i] = state[i];
      width_nxt[i] = width[i];
      acc[i]       = 1'b0;
      rej[i]       = 1'b0;
      case (state[i])
        WAIT_LOW: if (!sync_p1[i]) state_nxt[i] = IDLE;
        IDLE: begin
          if (rise_p2[i]) begin
            width_nxt[i] = '0;
            state_nxt[i] = MEASURE;
          end
        end
        MEASURE: begin
          width_nxt[i] = width_inc[i];
          if (fall_p2[i]) begin
            state_nxt[i] = IDLE;
            if (width_inc[i] < SHORT_LIM) rej[i] = 1'b1;
            else                          acc[i] = 1'b1;
          end else if (width_inc[i] > LONG_LIM) begin
            rej[i]       = 1'b1;
            state_nxt[i] = WAIT_LOW;
          end
        end
        default: state_nxt[i] = WAIT_LOW;
      endcase
    end
  end

  // stage p3: channel state, offsets and strobes
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) begin
        state[i] <= WAIT_LOW;
        width[i] <= '0;
        off[i]   <= '0;
      end
      offset_update <= '0;
      pulse_error   <= '0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        state[i] <= state_nxt[i];
        width[i] <= width_nxt[i];
        if (acc[i]) off[i] <= to_offset(width_inc[i], (i == 0) ? W_MIN : W_MID);
      end
      offset_update <= acc;
      pulse_error   <= rej;
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (!rst_n || acc[i])                  silence[i] <= '0;
      else if (us_tick && silence[i] != S_MAX) silence[i] <= silence[i] + SW'(1);
    end
  end

  // Any channel still timed out restarts the "heard from everyone" tally.
  always_comb begin
    for (int i = 0; i < 4; i++) to_vec[i] = (silence[i] == S_MAX);
    seen_nxt = ((|to_vec) ? 4'b0 : seen) | acc;
    fs_nxt   = (failsafe || (|to_vec)) && (seen_nxt != 4'hF);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      failsafe <= 1'b1;
      seen     <= '0;
    end else begin
      failsafe <= fs_nxt;
      seen     <= fs_nxt ? seen_nxt : 4'b0;
    end
  end

  assign throttle_offset = failsafe ? '0 : off[0];
  assign pitch_offset    = failsafe ? '0 : off[1];
  assign roll_offset     = failsafe ? '0 : off[2];
  assign yaw_offset      = failsafe ? '0 : off[3];

endmodule

// File: tb/tb_rc_receiver_decoder.sv
// Randomized and directed bench for rc_receiver_decoder against a pulse-level
// reference model (classify width, clamp, subtract centre; failsafe tally).
module tb_rc_receiver_decoder;

  localparam int T  = 2;
  localparam int TO = 6000;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [3:0] pins = 4'b0;
  logic [11:0] thr_o, pit_o, rol_o, yaw_o;
  logic [3:0] upd, err;
  logic fs;

  rc_receiver_decoder #(.TICKS_PER_US(T), .TIMEOUT_US(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .rc_throttle(pins[0]), .rc_pitch(pins[1]), .rc_roll(pins[2]), .rc_yaw(pins[3]),
    .throttle_offset(thr_o), .pitch_offset(pit_o), .roll_offset(rol_o), .yaw_offset(yaw_o),
    .offset_update(upd), .pulse_error(err), .failsafe(fs)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check_eq(input string tag, input int got, input int exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // reference model state
  int   exp_off [4];
  bit   mfs;
  bit [3:0] mseen;
  bit   yaw_to;
  bit   last_acc [4];

  // frame description and per-frame observations
  int fh [4];
  int fst [4];
  bit fen [4];
  int ucnt [4], ecnt [4], ucyc [4], ecyc [4], udisp [4], fcyc [4], rcyc [4];

  function automatic bit accepted(input int h);
    return (h >= 850) && (h <= 2151);
  endfunction

  function automatic int exp_value(input int ch, input int h);
    int c;
    c = (h < 1000) ? 1000 : (h > 2000) ? 2000 : h;
    return (ch == 0) ? c - 1000 : c - 1500;
  endfunction

  function automatic int to12(input int v);
    return v & 32'hFFF;
  endfunction

  function automatic int disp_of(input int ch);
    case (ch)
      0: return int'(thr_o);
      1: return int'(pit_o);
      2: return int'(rol_o);
      3: return int'(yaw_o);
      default: return 0;
    endcase
  endfunction

  // mode: 0 = no check of output at strobe, 1 = value shown, 2 = forced to zero
  task automatic run_frame(input string name, input int mode, input bit chk_end);
    int len;
    bit [3:0] am;
    len = 0;
    am  = 4'b0;
    for (int ch = 0; ch < 4; ch++) begin
      ucnt[ch] = 0; ecnt[ch] = 0; ucyc[ch] = 0; ecyc[ch] = 0;
      udisp[ch] = 0; fcyc[ch] = 0; rcyc[ch] = 0;
      if (fen[ch] && fst[ch] + fh[ch] * T > len) len = fst[ch] + fh[ch] * T;
    end
    len += 10;
    for (int c = 0; c < len; c++) begin
      @(posedge clk); #1;
      for (int ch = 0; ch < 4; ch++) begin
        pins[ch] = fen[ch] && (c >= fst[ch]) && (c < fst[ch] + fh[ch] * T);
        if (fen[ch] && c == fst[ch]) rcyc[ch] = cyc;
        if (fen[ch] && c == fst[ch] + fh[ch] * T) fcyc[ch] = cyc;
      end
      @(negedge clk);
      for (int ch = 0; ch < 4; ch++) begin
        if (upd[ch]) begin ucnt[ch]++; ucyc[ch] = cyc; udisp[ch] = disp_of(ch); end
        if (err[ch]) begin ecnt[ch]++; ecyc[ch] = cyc; end
      end
    end
    for (int ch = 0; ch < 4; ch++) begin
      if (!fen[ch]) begin
        check_eq($sformatf("%s.ch%0d.upd_idle", name, ch), ucnt[ch], 0);
        check_eq($sformatf("%s.ch%0d.err_idle", name, ch), ecnt[ch], 0);
        last_acc[ch] = 1'b0;
      end else if (accepted(fh[ch])) begin
        exp_off[ch] = exp_value(ch, fh[ch]);
        am[ch] = 1'b1;
        last_acc[ch] = 1'b1;
        check_eq($sformatf("%s.ch%0d.upd_cnt", name, ch), ucnt[ch], 1);
        check_eq($sformatf("%s.ch%0d.err_cnt", name, ch), ecnt[ch], 0);
        check_eq($sformatf("%s.ch%0d.latency", name, ch), ucyc[ch] - fcyc[ch], 4);
        if (mode == 1) check_eq($sformatf("%s.ch%0d.strobe_val", name, ch), udisp[ch], to12(exp_off[ch]));
        if (mode == 2) check_eq($sformatf("%s.ch%0d.strobe_zero", name, ch), udisp[ch], 0);
      end else begin
        last_acc[ch] = 1'b0;
        check_eq($sformatf("%s.ch%0d.upd_rej", name, ch), ucnt[ch], 0);
        check_eq($sformatf("%s.ch%0d.err_rej", name, ch), ecnt[ch], 1);
      end
    end
    if (yaw_to && am[3]) yaw_to = 1'b0;
    if (!yaw_to) mseen |= am;
    if (mfs && mseen == 4'hF) begin mfs = 1'b0; mseen = 4'b0; end
    if (chk_end) begin
      check_eq($sformatf("%s.failsafe", name), int'(fs), int'(mfs));
      for (int ch = 0; ch < 4; ch++)
        check_eq($sformatf("%s.ch%0d.out", name, ch), disp_of(ch), mfs ? 0 : to12(exp_off[ch]));
    end
  endtask

  task automatic set_frame(input int h0, input int h1, input int h2, input int h3,
                           input bit e0, input bit e1, input bit e2, input bit e3);
    fh[0] = h0; fh[1] = h1; fh[2] = h2; fh[3] = h3;
    fen[0] = e0; fen[1] = e1; fen[2] = e2; fen[3] = e3;
    for (int ch = 0; ch < 4; ch++) fst[ch] = 0;
  endtask

  task automatic check_reset_state(input string name);
    check_eq({name, ".failsafe"}, int'(fs), 1);
    check_eq({name, ".upd"}, int'(upd), 0);
    check_eq({name, ".err"}, int'(err), 0);
    for (int ch = 0; ch < 4; ch++) check_eq($sformatf("%s.ch%0d.out", name, ch), disp_of(ch), 0);
  endtask

  initial begin
    #(10 * 95000);
    $display("FAIL watchdog: simulation exceeded cycle budget, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int d, quiet_u, quiet_e;
    for (int ch = 0; ch < 4; ch++) begin exp_off[ch] = 0; last_acc[ch] = 1'b1; end
    mfs = 1'b1; mseen = 4'b0; yaw_to = 1'b0;

    repeat (10) @(posedge clk);
    @(negedge clk);
    check_reset_state("reset");
    @(posedge clk); #1 rst_n = 1'b1;

    // centre pulses on all channels clear the power-on failsafe
    set_frame(1500, 1500, 1500, 1500, 1, 1, 1, 1);
    run_frame("centre", 1, 1);

    // clamp high, overlong reject, short reject
    set_frame(2100, 2300, 800, 1700, 1, 1, 1, 1);
    run_frame("limits", 1, 1);
    d = ecyc[1] - rcyc[1];
    check_eq("limits.pitch_err_time", int'(d >= 2151 * T - T && d <= 2151 * T + 6), 1);

    set_frame(1500, 1200, 1000, 1500, 1, 1, 1, 1);
    run_frame("recover", 1, 1);
    check_eq("recover.roll_hex", int'(rol_o), 32'hE0C);

    // acceptance-window edges
    set_frame(850, 2150, 849, 2000, 1, 1, 1, 1);
    run_frame("edges", 1, 1);

    for (int f = 0; f < 6; f++) begin
      for (int ch = 0; ch < 4; ch++) begin
        int cat;
        fen[ch] = 1'b1;
        fst[ch] = $urandom_range(0, 40);
        cat = $urandom_range(0, 9);
        if (!last_acc[ch] && (cat == 7 || cat == 8)) cat = 0;
        case (cat)
          5:       fh[ch] = $urandom_range(850, 999);
          6:       fh[ch] = $urandom_range(2001, 2150);
          7:       fh[ch] = $urandom_range(300, 849);
          8:       fh[ch] = $urandom_range(2152, 2300);
          default: fh[ch] = $urandom_range(1000, 2000);
        endcase
      end
      run_frame($sformatf("rand%0d", f), 1, 1);
    end

    // yaw goes silent while the others keep pulsing
    set_frame(1400, 1600, 1450, 1550, 1, 1, 1, 1);
    run_frame("steady", 1, 1);
    for (int f = 0; f < 3; f++) begin
      set_frame(1500 + 10 * f, 1500 - 10 * f, 1500 + 20 * f, 1500, 1, 1, 1, 0);
      run_frame($sformatf("silent%0d", f), 1, 1);
    end
    set_frame(1500, 1500, 1500, 1500, 1, 1, 1, 0);
    run_frame("silent3", 0, 0);
    mfs = 1'b1; mseen = 4'b0; yaw_to = 1'b1;
    set_frame(1500, 1300, 1700, 1500, 1, 1, 1, 0);
    run_frame("silent4", 2, 1);
    set_frame(1500, 1500, 1500, 1600, 0, 0, 0, 1);
    run_frame("yaw_back", 2, 1);
    set_frame(1700, 1700, 1700, 1500, 1, 1, 1, 0);
    run_frame("all_back", 1, 1);

    // reset in the middle of a pulse on every channel
    @(posedge clk); #1 pins = 4'hF;
    repeat (500) @(posedge clk);
    #1 rst_n = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk);
    check_reset_state("midrst");
    @(posedge clk); #1 rst_n = 1'b1;
    for (int ch = 0; ch < 4; ch++) exp_off[ch] = 0;
    mfs = 1'b1; mseen = 4'b0; yaw_to = 1'b0;
    quiet_u = 0; quiet_e = 0;
    for (int c = 0; c < 420; c++) begin
      @(posedge clk); #1;
      if (c == 400) pins = 4'h0;
      @(negedge clk);
      if (upd != 4'b0) quiet_u++;
      if (err != 4'b0) quiet_e++;
    end
    check_eq("midrst.trunc_upd", quiet_u, 0);
    check_eq("midrst.trunc_err", quiet_e, 0);
    check_eq("midrst.fs_hold", int'(fs), 1);
    set_frame(1800, 1800, 1800, 1800, 1, 1, 1, 1);
    run_frame("after_rst", 1, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
